irq_source_gate: RTL and testbench
==================================

# irq_source_gate

Upstream front end for the bus interrupt controller. Captures eight raw device interrupt sources, synchronises them to `clk`, and latches each one as an edge or level request. Each line has a CPU-programmable mask. The result drives the controller's active-low `b_irq_n[7:0]` inputs, and a small register window on the same 14-bit address bus lets software inspect and clear requests.

## Interface
Parameters:
- `BASE_ADDR`, default 14'h2010: word address of register 0. Registers sit at BASE+0/2/4/6, clear of the controller window 14'h2000–14'h2004.
- `NUM_LINES`, default 8: fixed at 8 in this revision; any other value is unsupported.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `src_irq`, in, 8: raw device requests, active-high, asynchronous to `clk`.
- `addr_bus`, in, 14: CPU address.
- `read_n`, in, 1: active-low read strobe.
- `write_n`, in, 1: active-low write strobe.
- `data_in`, in, 16: CPU write data.
- `data_out`, out, 16: registered read data; 16'h0000 when not returning a read.
- `data_valid`, out, 1: high for one cycle when `data_out` carries read data.
- `b_irq_n`, out, 8: active-low gated requests to the interrupt controller.

## Operation
Registers (upper bytes read 0 unless listed; writes to read-only registers are ignored):
- BASE+0 PEND
  - Read: {overrun[7:0], pending[7:0]}.
  - Write-1-to-clear: `data_in[i]` clears `pending[i]`, `data_in[i+8]` clears `overrun[i]`.
- BASE+2 MASK: R/W [7:0]; 1 = enabled. Reset 8'h00.
- BASE+4 MODE: R/W [7:0]; 1 = edge, 0 = level. Reset 8'hFF.
- BASE+6 RAW: read-only synchronised levels `s2[7:0]`.

Per-line behaviour:
- Synchroniser chain `s1 -> s2 -> s3`, all 0 after reset. Rising edge detected when `s2 & ~s3`.
- Edge mode:
  - Rising edge sets `pending`.
  - Rising edge while `pending` is already 1 also sets `overrun`.
  - If a set and a W1C clear hit the same cycle, the set wins.
- Level mode:
  - `pending` mirrors `s2` every cycle.
  - W1C on a level-mode pending bit has no effect.
  - `overrun` is never set in level mode.
- MODE write changing a line from level to edge clears that line's `pending` and `overrun` in the same cycle.
- `b_irq_n[i] <= ~(pending[i] & mask[i])`, registered. Masking never clears `pending`.

Bus rules:
- Address decode requires an exact 14-bit match; other addresses are ignored with no side effects.
- Reads have no side effects.
- `read_n` and `write_n` low together: the write executes, and the read returns the pre-write value.

## Timing
- Reset values:
  - `data_out` 0, `data_valid` 0, `b_irq_n` 8'hFF.
  - `pending`, `overrun`, `MASK`, and all synchroniser flops 0.
  - `MODE` 8'hFF.
- Source-to-output latency for a `src_irq` rising before clock edge E0:
  - `s1` at E0, `s2` at E1, `pending` set at E2, `b_irq_n` low at E3.
  - Total: 4 cycles counting E0.
- Read latency: `read_n` low at edge E gives `data_out`/`data_valid` at E+1. `data_valid` stays high every cycle `read_n` is sampled low on a matching address.
- Write effect is visible in the register at the next edge, and on `b_irq_n` one edge later.
- Reset mid-operation: all state returns to reset values at the next edge regardless of in-flight bus cycles. A `src_irq` already high when `rst` deasserts produces an edge after `s2`/`s3` refill.
- Pulses on `src_irq` shorter than one `clk` period may be lost. Devices must hold requests for at least 2 cycles.

## Structure
- Package `interruptus_irq_pkg`:
  - `NUM_LINES`.
  - Register offsets `OFS_PEND=0`, `OFS_MASK=2`, `OFS_MODE=4`, `OFS_RAW=6`.
  - Reset constants for `MASK` and `MODE`.
- Sub-module `irq_sync_edge`, instantiated 8×: 3-flop synchroniser plus rise detect. Outputs `level` (s2) and `rise`.
- Top level holds the registers, address decode, W1C/set arbitration, and output gating.

## Test plan
- Reset, then read BASE+4 and BASE+2 -> 16'h00FF and 16'h0000 one cycle after `read_n`; `b_irq_n` = 8'hFF throughout.
- Write MASK = 8'h08, raise `src_irq[3]` -> `b_irq_n` = 8'hF7 exactly 4 cycles later. Read PEND -> 16'h0008. Write 16'h0008 to PEND -> `b_irq_n` returns to 8'hFF two edges later.
- Two rising edges on line 5 without a clear -> PEND reads 16'h2020. Write 16'h2000 -> PEND reads 16'h0020.
- MODE = 8'hFE, MASK = 8'h01, hold `src_irq[0]` high -> `b_irq_n[0]` = 0. W1C bit 0 -> no change. Drop `src_irq[0]` -> `b_irq_n[0]` = 1 after 4 cycles.
- In edge mode, a W1C of pending[2] on the same cycle that a new rise on line 2 is detected -> `pending[2]` remains 1. Assert `rst` mid-read -> `data_valid` = 0 and all state at reset values on the next edge.

Source files
------------

// File: rtl/interruptus_irq_pkg.sv
// Shared constants and register decode for the interrupt source gate.
package interruptus_irq_pkg;

  localparam int NUM_LINES = 8;
  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 16;

  localparam logic [ADDR_W-1:0] OFS_PEND = 14'd0;
  localparam logic [ADDR_W-1:0] OFS_MASK = 14'd2;
  localparam logic [ADDR_W-1:0] OFS_MODE = 14'd4;
  localparam logic [ADDR_W-1:0] OFS_RAW  = 14'd6;

  localparam logic [NUM_LINES-1:0] MASK_RST = 8'h00;
  localparam logic [NUM_LINES-1:0] MODE_RST = 8'hFF;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_PEND,
    SEL_MASK,
    SEL_MODE,
    SEL_RAW
  } reg_sel_e;

  // Exact 14-bit match only; anything else selects nothing.
  function automatic reg_sel_e decode_reg(input logic [ADDR_W-1:0] addr,
                                          input logic [ADDR_W-1:0] base);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (addr == base + OFS_PEND) sel = SEL_PEND;
    if (addr == base + OFS_MASK) sel = SEL_MASK;
    if (addr == base + OFS_MODE) sel = SEL_MODE;
    if (addr == base + OFS_RAW)  sel = SEL_RAW;
    return sel;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Three-flop synchroniser for one raw interrupt source, with rising-edge detect.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = async_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // NOTE: non-blocking assignments so every flop samples its pre-edge input;
  // blocking here would collapse the chain into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;

endmodule

// File: rtl/irq_source_gate.sv
// Interrupt source front end: per-line edge/level capture, masking, and a
// four-register CPU window driving the controller's active-low request inputs.
module irq_source_gate #(
  parameter logic [13:0] BASE_ADDR = 14'h2010,
  parameter int          NUM_LINES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  src_irq,
  input  logic [13:0] addr_bus,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic [7:0]  b_irq_n
);
  import interruptus_irq_pkg::*;

  logic [7:0] level, rise;

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    irq_sync_edge u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (src_irq[i]),
      .level    (level[i]),
      .rise     (rise[i])
    );
  end

  logic [7:0]  mask_q, mask_d;
  logic [7:0]  mode_q, mode_d;
  logic [7:0]  pending_q, pending_d;
  logic [7:0]  overrun_q, overrun_d;
  logic [7:0]  irq_n_q, irq_n_d;
  logic [15:0] data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;

  reg_sel_e    sel;
  logic        rd_en, wr_en;
  logic [15:0] rdata;
  logic [7:0]  pend_clr, ovr_clr, to_edge;

  // NOTE: every signal gets a default before any branch, so no path through
  // this block leaves a value unassigned and no latch can be inferred.
  always_comb begin
    sel      = decode_reg(addr_bus, BASE_ADDR);
    rd_en    = ~read_n;
    wr_en    = ~write_n;
    rdata    = '0;
    mask_d   = mask_q;
    mode_d   = mode_q;
    pend_clr = '0;
    ovr_clr  = '0;

    unique case (sel)
      SEL_PEND: rdata = {overrun_q, pending_q};
      SEL_MASK: rdata = {8'h00, mask_q};
      SEL_MODE: rdata = {8'h00, mode_q};
      SEL_RAW:  rdata = {8'h00, level};
      SEL_NONE: rdata = '0;
    endcase

    // Reads see pre-write state, so a simultaneous read/write returns the old value.
    data_valid_d = rd_en && (sel != SEL_NONE);
    data_out_d   = data_valid_d ? rdata : 16'h0000;

    if (wr_en) begin
      if (sel == SEL_MASK) mask_d = data_in[7:0];
      if (sel == SEL_MODE) mode_d = data_in[7:0];
      if (sel == SEL_PEND) begin
        pend_clr = data_in[7:0];
        ovr_clr  = data_in[15:8];
      end
    end

    to_edge = ~mode_q & mode_d;

    // Edge lines: a new rise beats a same-cycle clear. Level lines follow s2.
    pending_d = (mode_q & (rise | (pending_q & ~pend_clr))) | (~mode_q & level);
    overrun_d = (overrun_q & ~ovr_clr) | (mode_q & rise & pending_q);
    pending_d = pending_d & ~to_edge;
    overrun_d = overrun_d & ~to_edge;

    irq_n_d = ~(pending_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q       <= MASK_RST;
      mode_q       <= MODE_RST;
      pending_q    <= '0;
      overrun_q    <= '0;
      irq_n_q      <= 8'hFF;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      mask_q       <= mask_d;
      mode_q       <= mode_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      irq_n_q      <= irq_n_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign b_irq_n    = irq_n_q;

endmodule

// File: tb/tb_irq_source_gate.sv
// Self-checking bench for irq_source_gate: register table, directed corner
// sequences, then random traffic against a behavioural model.
module tb_irq_source_gate;

  localparam logic [13:0] BASE = 14'h2010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  src_irq = '0;
  logic [13:0] addr_bus = '0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        data_valid;
  logic [7:0]  b_irq_n;

  int n_checks = 0;
  int n_fail   = 0;

  irq_source_gate #(.BASE_ADDR(BASE), .NUM_LINES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_irq    (src_irq),
    .addr_bus   (addr_bus),
    .read_n     (read_n),
    .write_n    (write_n),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .b_irq_n    (b_irq_n)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: tracks the last three samples of each source and applies
  // the register rules line by line.
  logic [7:0]  m_pend = '0, m_ovr = '0, m_mask = '0, m_mode = 8'hFF, m_irq_n = 8'hFF;
  logic [15:0] m_dout = '0;
  logic        m_valid = 1'b0;
  logic [7:0]  h0 = '0, h1 = '0, h2 = '0;

  always @(posedge clk) begin : ref_model
    logic [7:0]  np, no, nmask, nmode;
    logic [15:0] rv;
    logic        hit, rd, wr;
    int          ofs;
    if (rst) begin
      m_pend = '0; m_ovr = '0; m_mask = '0; m_mode = 8'hFF; m_irq_n = 8'hFF;
      m_dout = '0; m_valid = 1'b0; h0 = '0; h1 = '0; h2 = '0;
    end else begin
      rd  = !read_n;
      wr  = !write_n;
      ofs = int'(addr_bus) - int'(BASE);
      hit = 1'b1;
      rv  = '0;
      case (ofs)
        0: rv = {m_ovr, m_pend};
        2: rv = {8'h00, m_mask};
        4: rv = {8'h00, m_mode};
        6: rv = {8'h00, h1};
        default: hit = 1'b0;
      endcase
      np = m_pend; no = m_ovr; nmask = m_mask; nmode = m_mode;
      if (wr && ofs == 2) nmask = data_in[7:0];
      if (wr && ofs == 4) nmode = data_in[7:0];
      for (int i = 0; i < 8; i++) begin
        if (wr && ofs == 0 && data_in[i+8]) no[i] = 1'b0;
        if (m_mode[i]) begin
          if (h1[i] && !h2[i]) begin
            np[i] = 1'b1;
            if (m_pend[i]) no[i] = 1'b1;
          end else if (wr && ofs == 0 && data_in[i]) begin
            np[i] = 1'b0;
          end
        end else begin
          np[i] = h1[i];
        end
        if (!m_mode[i] && nmode[i]) begin
          np[i] = 1'b0;
          no[i] = 1'b0;
        end
      end
      m_irq_n = ~(m_pend & m_mask);
      m_valid = rd && hit;
      m_dout  = (rd && hit) ? rv : 16'h0000;
      m_pend = np; m_ovr = no; m_mask = nmask; m_mode = nmode;
      h2 = h1; h1 = h0; h0 = src_irq;
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_write(input logic [13:0] a, input logic [15:0] d);
    addr_bus = a; data_in = d; write_n = 1'b0;
    step();
    write_n = 1'b1;
  endtask

  task automatic do_read(input string name, input logic [13:0] a, input logic [15:0] exp);
    addr_bus = a; read_n = 1'b0;
    step();
    read_n = 1'b1;
    check({name, " data"}, data_out, exp);
    check({name, " valid"}, {15'd0, data_valid}, 16'd1);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [13:0] addr;
    logic [15:0] din;
    logic [15:0] exp_dout;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[13];
  logic [13:0] rand_addrs[6];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, BASE + 14'd2, 16'hFF5A, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, BASE + 14'd2, 16'h0000, 16'h005A, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, BASE + 14'd4, 16'h003C, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, BASE + 14'd4, 16'h0000, 16'h003C, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, BASE + 14'd2, 16'h00C3, 16'h005A, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, BASE + 14'd2, 16'h0000, 16'h00C3, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, BASE + 14'd6, 16'h00FF, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, BASE + 14'd6, 16'h0000, 16'h0000, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, BASE + 14'd1, 16'h0000, 16'h0000, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, BASE + 14'd3, 16'h0011, 16'h0000, 1'b0};
    vecs[10] = '{1'b1, 1'b0, BASE + 14'd2, 16'h0000, 16'h00C3, 1'b1};
    vecs[11] = '{1'b1, 1'b0, BASE - 14'd2, 16'h0000, 16'h0000, 1'b0};
    vecs[12] = '{1'b1, 1'b0, BASE + 14'd0, 16'h0000, 16'h0000, 1'b1};
    rand_addrs = '{BASE, BASE + 14'd2, BASE + 14'd4, BASE + 14'd6, BASE + 14'd1, BASE + 14'd8};

    // Reset state and default register values.
    rst = 1'b1;
    step(3);
    check("reset b_irq_n", {8'h00, b_irq_n}, 16'h00FF);
    check("reset data_out", data_out, 16'h0000);
    check("reset data_valid", {15'd0, data_valid}, 16'd0);
    rst = 1'b0;
    step();
    do_read("reset MODE", BASE + 14'd4, 16'h00FF);
    do_read("reset MASK", BASE + 14'd2, 16'h0000);
    check("reset b_irq_n idle", {8'h00, b_irq_n}, 16'h00FF);

    // Register access table.
    for (int i = 0; i < 13; i++) begin
      addr_bus = vecs[i].addr;
      data_in  = vecs[i].din;
      read_n   = !vecs[i].rd;
      write_n  = !vecs[i].wr;
      step();
      check($sformatf("vec%0d data_out", i), data_out, vecs[i].exp_dout);
      check($sformatf("vec%0d data_valid", i), {15'd0, data_valid}, {15'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d b_irq_n", i), {8'h00, b_irq_n}, 16'h00FF);
    end
    read_n = 1'b1; write_n = 1'b1;
    rst = 1'b1; step(); rst = 1'b0; step();

    // Edge latency on line 3, then W1C.
    do_write(BASE + 14'd2, 16'h0008);
    src_irq[3] = 1'b1;
    step(3);
    check("line3 latency not early", {8'h00, b_irq_n}, 16'h00FF);
    step();
    check("line3 latency 4 cycles", {8'h00, b_irq_n}, 16'h00F7);
    do_read("line3 PEND", BASE, 16'h0008);
    do_write(BASE, 16'h0008);
    check("line3 clear +1", {8'h00, b_irq_n}, 16'h00F7);
    step();
    check("line3 clear +2", {8'h00, b_irq_n}, 16'h00FF);
    src_irq[3] = 1'b0;

    // Two rises on line 5 produce overrun; clear overrun alone.
    src_irq[5] = 1'b1; step(2); src_irq[5] = 1'b0; step(3);
    src_irq[5] = 1'b1; step(2); src_irq[5] = 1'b0; step(4);
    do_read("line5 overrun", BASE, 16'h2020);
    do_write(BASE, 16'h2000);
    do_read("line5 overrun cleared", BASE, 16'h0020);
    do_write(BASE, 16'h0020);

    // Level mode on line 0.
    do_write(BASE + 14'd4, 16'h00FE);
    do_write(BASE + 14'd2, 16'h0001);
    src_irq[0] = 1'b1;
    step(5);
    check("level line0 asserted", {8'h00, b_irq_n}, 16'h00FE);
    do_read("level RAW", BASE + 14'd6, 16'h0001);
    do_write(BASE, 16'h0001);
    step(2);
    check("level W1C ignored", {8'h00, b_irq_n}, 16'h00FE);
    src_irq[0] = 1'b0;
    step(3);
    check("level drop not early", {8'h00, b_irq_n}, 16'h00FE);
    step();
    check("level drop 4 cycles", {8'h00, b_irq_n}, 16'h00FF);
    src_irq[0] = 1'b1;
    step(5);
    do_write(BASE + 14'd4, 16'h00FF);
    do_read("level->edge clears", BASE, 16'h0000);
    src_irq[0] = 1'b0;
    step(3);

    // Same-cycle rise and W1C on line 2: the rise wins.
    do_write(BASE + 14'd2, 16'h0004);
    src_irq[2] = 1'b1; step(2); src_irq[2] = 1'b0; step(3);
    check("line2 first rise", {8'h00, b_irq_n}, 16'h00FB);
    src_irq[2] = 1'b1;
    step(2);
    do_write(BASE, 16'h0004);
    do_read("line2 set beats clear", BASE, 16'h0404);
    check("line2 still requested", {8'h00, b_irq_n}, 16'h00FB);
    src_irq[2] = 1'b0;
    do_write(BASE, 16'h0404);
    step(2);

    // Reset during a read; a source held across reset yields a fresh edge.
    do_write(BASE + 14'd2, 16'h00FF);
    src_irq[1] = 1'b1;
    step(5);
    check("pre-reset request", {8'h00, b_irq_n}, 16'h00FD);
    addr_bus = BASE + 14'd2; read_n = 1'b0; rst = 1'b1;
    step();
    check("mid-read reset valid", {15'd0, data_valid}, 16'd0);
    check("mid-read reset data", data_out, 16'h0000);
    check("mid-read reset b_irq_n", {8'h00, b_irq_n}, 16'h00FF);
    rst = 1'b0; read_n = 1'b1;
    step();
    do_read("post-reset MASK", BASE + 14'd2, 16'h0000);
    do_read("post-reset MODE", BASE + 14'd4, 16'h00FF);
    step(3);
    do_read("held source re-edges", BASE, 16'h0002);
    src_irq[1] = 1'b0;
    do_write(BASE, 16'h0202);
    step(3);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      int op;
      if (k % 2 == 0) src_irq = src_irq ^ (8'($urandom) & 8'($urandom));
      op       = int'($urandom_range(0, 3));
      addr_bus = rand_addrs[$urandom_range(0, 5)];
      data_in  = 16'($urandom);
      read_n   = !(op == 1 || op == 3);
      write_n  = !(op == 2 || op == 3);
      step();
      check($sformatf("rand%0d b_irq_n", k), {8'h00, b_irq_n}, {8'h00, m_irq_n});
      check($sformatf("rand%0d data_out", k), data_out, m_dout);
      check($sformatf("rand%0d data_valid", k), {15'd0, data_valid}, {15'd0, m_valid});
    end
    read_n = 1'b1; write_n = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
